// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter.
// Holds the default widths and sizes used by the arbiter and its round-robin
// grant sub-module. It also provides the index-width helper that sizes the
// tag and requester index fields.
package mem_req_arbiter_pkg;

    localparam int NUM_REQ_DEF       = 2;
    localparam int ADDR_WIDTH_DEF    = 48;
    localparam int DATA_WIDTH_DEF    = 64;
    localparam int LOCAL_TAG_W_DEF   = 2;
    localparam int MEM_TAG_COUNT_DEF = 8;

    // Ceiling log2 of count. The result is never below 1, so a
    // single-entry index still gets a real bit.
    function automatic int idx_width(input int count);
        int width;
        width = 1;
        for (int b = 1; b < 31; b++) begin
            if ((32'sd1 <<< b) < count) begin
                width = b + 32'sd1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr.sv
// Round-robin grant generator for the memory request arbiter.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   req       - one bit per requester with a pending (full) holding register
//   advance   - an issue happens this cycle; the pointer moves past the winner
//   gnt       - one-hot grant (combinational)
//   gnt_idx   - binary index of the granted requester (combinational)
// The pointer names the first requester to search. After a grant to g it
// becomes g+1 modulo NUM_REQ. It only moves when an issue actually happens.
module mem_req_arbiter_rr
    import mem_req_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic             found_s;
    int               pos_s;
    int               nxt_s;

    // Search from the pointer, wrapping around; the first pending requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s = (int'(ptr_r) + k) % NUM_REQ;
            if (!found_s && req[IDX_W'(pos_s)]) begin
                found_s            = 1'b1;
                gnt[IDX_W'(pos_s)] = 1'b1;
                gnt_idx            = IDX_W'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer value that takes effect after an issue to gnt_idx.
    always_comb begin
        nxt_s     = (int'(gnt_idx) + 32'sd1) % NUM_REQ;
        ptr_nxt_s = IDX_W'(nxt_s);
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one tagged memory request/response port among NUM_REQ requesters.
// Each requester has a one-deep holding register. Full registers are granted
// round-robin, and each issued request takes the lowest free global tag. The
// tag table remembers the owner and the local tag, so each response goes back
// to the right requester with the tag that requester used.
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   in_req/in_tag/in_addr   - per-requester request strobe, local tag and address (slice i)
//   in_stall      - holding register of requester i is full
//   out_push/out_tag/out_data - one-hot response strobe to the owner, local tag, data
//   mem_req/mem_tag/mem_addr  - registered memory request, global tag and address
//   mem_stall     - memory cannot take a request this cycle
//   mem_push/mem_push_tag/mem_data - memory response strobe, global tag, data
//   busy          - any holding register full or any tag outstanding
//   protocol_err  - sticky: request while stalled, or response on an unused tag
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int  NUM_REQ       = NUM_REQ_DEF,
    parameter int  ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int  DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int  LOCAL_TAG_W   = LOCAL_TAG_W_DEF,
    parameter int  MEM_TAG_COUNT = MEM_TAG_COUNT_DEF,
    localparam int MEM_TAG_W     = idx_width(MEM_TAG_COUNT),
    localparam int REQ_IDX_W     = idx_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             in_req,
    input  logic [NUM_REQ*LOCAL_TAG_W-1:0] in_tag,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  in_addr,
    output logic [NUM_REQ-1:0]             in_stall,
    output logic [NUM_REQ-1:0]             out_push,
    output logic [LOCAL_TAG_W-1:0]         out_tag,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           mem_req,
    output logic [MEM_TAG_W-1:0]           mem_tag,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_stall,
    input  logic                           mem_push,
    input  logic [MEM_TAG_W-1:0]           mem_push_tag,
    input  logic [DATA_WIDTH-1:0]          mem_data,
    output logic                           busy,
    output logic                           protocol_err
);

    // Holding registers, one per requester.
    logic [NUM_REQ-1:0]       full_r;
    logic [LOCAL_TAG_W-1:0]   hold_tag_r  [NUM_REQ];
    logic [ADDR_WIDTH-1:0]    hold_addr_r [NUM_REQ];

    // Global tag table.
    logic [MEM_TAG_COUNT-1:0] tag_valid_r;
    logic [REQ_IDX_W-1:0]     tag_owner_r [MEM_TAG_COUNT];
    logic [LOCAL_TAG_W-1:0]   tag_local_r [MEM_TAG_COUNT];

    // Registered outputs.
    logic                     mem_req_r;
    logic [MEM_TAG_W-1:0]     mem_tag_r;
    logic [ADDR_WIDTH-1:0]    mem_addr_r;
    logic [NUM_REQ-1:0]       out_push_r;
    logic [LOCAL_TAG_W-1:0]   out_tag_r;
    logic [DATA_WIDTH-1:0]    out_data_r;
    logic                     protocol_err_r;

    logic [NUM_REQ-1:0]       capture_s;
    logic [NUM_REQ-1:0]       drop_s;
    logic [NUM_REQ-1:0]       gnt_s;
    logic [REQ_IDX_W-1:0]     gnt_idx_s;
    logic                     free_found_s;
    logic [MEM_TAG_W-1:0]     free_tag_s;
    logic                     issue_s;
    logic                     resp_hit_s;
    logic                     resp_bad_s;
    logic [NUM_REQ-1:0]       push_onehot_s;

    assign capture_s = in_req & ~full_r;
    assign drop_s    = in_req & full_r;

    // Pick the lowest free tag. The table is read as registered, so a tag
    // freed by a response this cycle can only be reused next cycle.
    always_comb begin
        free_found_s = 1'b0;
        free_tag_s   = '0;
        for (int t = 0; t < MEM_TAG_COUNT; t++) begin
            if (!free_found_s && !tag_valid_r[t]) begin
                free_found_s = 1'b1;
                free_tag_s   = MEM_TAG_W'(t);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    assign issue_s = (|full_r) & free_found_s & ~mem_stall;

    mem_req_arbiter_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (full_r),
        .advance (issue_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Classify the memory response and build the one-hot strobe to its owner.
    always_comb begin
        resp_hit_s    = mem_push &  tag_valid_r[mem_push_tag];
        resp_bad_s    = mem_push & ~tag_valid_r[mem_push_tag];
        push_onehot_s = '0;
        if (resp_hit_s) begin
            push_onehot_s[tag_owner_r[mem_push_tag]] = 1'b1;
        end else begin
            push_onehot_s = '0;
        end
    end

    // Holding registers. Capture and issue never hit the same slot in the
    // same cycle: capture needs the slot empty, and issue needs it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_tag_r[i]  <= '0;
                hold_addr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture_s[i]) begin
                    full_r[i]      <= 1'b1;
                    hold_tag_r[i]  <= in_tag[i*LOCAL_TAG_W +: LOCAL_TAG_W];
                    hold_addr_r[i] <= in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end else if (issue_s && gnt_s[i]) begin
                    full_r[i] <= 1'b0;
                end else begin
                    full_r[i] <= full_r[i];
                end
            end
        end
    end

    // Tag table. A response retires a valid tag, and an issue claims a free
    // one, so the two updates never touch the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_r <= '0;
            for (int t = 0; t < MEM_TAG_COUNT; t++) begin
                tag_owner_r[t] <= '0;
                tag_local_r[t] <= '0;
            end
        end else begin
            if (resp_hit_s) begin
                tag_valid_r[mem_push_tag] <= 1'b0;
            end
            if (issue_s) begin
                tag_valid_r[free_tag_s] <= 1'b1;
                tag_owner_r[free_tag_s] <= gnt_idx_s;
                tag_local_r[free_tag_s] <= hold_tag_r[gnt_idx_s];
            end
        end
    end

    // Registered request, response and error outputs. The data fields keep
    // their last value between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r      <= 1'b0;
            mem_tag_r      <= '0;
            mem_addr_r     <= '0;
            out_push_r     <= '0;
            out_tag_r      <= '0;
            out_data_r     <= '0;
            protocol_err_r <= 1'b0;
        end else begin
            mem_req_r  <= issue_s;
            out_push_r <= push_onehot_s;
            if (issue_s) begin
                mem_tag_r  <= free_tag_s;
                mem_addr_r <= hold_addr_r[gnt_idx_s];
            end
            if (resp_hit_s) begin
                out_tag_r  <= tag_local_r[mem_push_tag];
                out_data_r <= mem_data;
            end
            protocol_err_r <= protocol_err_r | (|drop_s) | resp_bad_s;
        end
    end

    assign in_stall     = full_r;
    assign mem_req      = mem_req_r;
    assign mem_tag      = mem_tag_r;
    assign mem_addr     = mem_addr_r;
    assign out_push     = out_push_r;
    assign out_tag      = out_tag_r;
    assign out_data     = out_data_r;
    assign protocol_err = protocol_err_r;
    assign busy         = (|full_r) | (|tag_valid_r);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter.
// Expected memory requests and responses are queued when stimulus is driven.
// A negedge monitor pops and compares them whenever the DUT strobes mem_req
// or out_push.
module tb_mem_req_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  in_req;
    logic [3:0]  in_tag;
    logic [95:0] in_addr;
    logic [1:0]  in_stall;
    logic [1:0]  out_push;
    logic [1:0]  out_tag;
    logic [63:0] out_data;
    logic        mem_req;
    logic [2:0]  mem_tag;
    logic [47:0] mem_addr;
    logic        mem_stall;
    logic        mem_push;
    logic [2:0]  mem_push_tag;
    logic [63:0] mem_data;
    logic        busy;
    logic        protocol_err;

    typedef struct {
        logic [2:0]  tag;
        logic [47:0] addr;
    } mem_exp_t;

    typedef struct {
        logic [1:0]  push;
        logic [1:0]  ltag;
        logic [63:0] data;
    } resp_exp_t;

    mem_exp_t  mem_q [$];
    resp_exp_t resp_q [$];
    logic      exp_owner [8];
    logic [1:0] exp_ltag [8];

    int checks = 0;
    int fails  = 0;
    int sent;

    mem_req_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .in_req       (in_req),
        .in_tag       (in_tag),
        .in_addr      (in_addr),
        .in_stall     (in_stall),
        .out_push     (out_push),
        .out_tag      (out_tag),
        .out_data     (out_data),
        .mem_req      (mem_req),
        .mem_tag      (mem_tag),
        .mem_addr     (mem_addr),
        .mem_stall    (mem_stall),
        .mem_push     (mem_push),
        .mem_push_tag (mem_push_tag),
        .mem_data     (mem_data),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int r, input logic [1:0] lt, input logic [47:0] a);
        in_req[r]          = 1'b1;
        in_tag[r*2 +: 2]   = lt;
        in_addr[r*48 +: 48] = a;
    endtask

    // One-cycle memory response; queues the forwarded result when one is expected.
    task automatic respond(input int t, input logic [63:0] d, input logic fwd);
        resp_exp_t e;
        mem_push     = 1'b1;
        mem_push_tag = 3'(t);
        mem_data     = d;
        if (fwd) begin
            e.push = 2'b00;
            e.push[exp_owner[t]] = 1'b1;
            e.ltag = exp_ltag[t];
            e.data = d;
            resp_q.push_back(e);
        end
        tick();
        mem_push = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_mem_q_left"},  64'(mem_q.size()),  64'd0);
        check({tag, "_resp_q_left"}, 64'(resp_q.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_req"},      64'(mem_req),      64'd0);
        check({tag, "_mem_tag"},      64'(mem_tag),      64'd0);
        check({tag, "_mem_addr"},     64'(mem_addr),     64'd0);
        check({tag, "_in_stall"},     64'(in_stall),     64'd0);
        check({tag, "_out_push"},     64'(out_push),     64'd0);
        check({tag, "_out_tag"},      64'(out_tag),      64'd0);
        check({tag, "_out_data"},     64'(out_data),     64'd0);
        check({tag, "_busy"},         64'(busy),         64'd0);
        check({tag, "_protocol_err"}, 64'(protocol_err), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        check_drained({tag, "_pre"});
        rst          = 1'b1;
        in_req       = 2'b00;
        mem_stall    = 1'b0;
        mem_push     = 1'b0;
        mem_q.delete();
        resp_q.delete();
        tick();
        @(negedge clk);
        check_idle(tag);
        rst = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every DUT strobe must match the head of its queue.
    always @(negedge clk) begin
        mem_exp_t  me;
        resp_exp_t re;
        if (!rst) begin
            if (mem_req) begin
                if (mem_q.size() == 0) begin
                    check("mon_unexpected_mem_req", 64'(mem_req), 64'd0);
                end else begin
                    me = mem_q.pop_front();
                    check("mon_mem_tag",  64'(mem_tag),  64'(me.tag));
                    check("mon_mem_addr", 64'(mem_addr), 64'(me.addr));
                end
            end
            if (out_push != 2'b00) begin
                if (resp_q.size() == 0) begin
                    check("mon_unexpected_out_push", 64'(out_push), 64'd0);
                end else begin
                    re = resp_q.pop_front();
                    check("mon_out_push", 64'(out_push), 64'(re.push));
                    check("mon_out_tag",  64'(out_tag),  64'(re.ltag));
                    check("mon_out_data", out_data,      re.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        in_req       = 2'b00;
        in_tag       = 4'h0;
        in_addr      = 96'h0;
        mem_stall    = 1'b0;
        mem_push     = 1'b0;
        mem_push_tag = 3'd0;
        mem_data     = 64'h0;
        tick();
        do_reset("rst0");

        // 1: single request, reply three cycles after issue
        drive_req(0, 2'd2, 48'h10);
        mem_q.push_back('{tag: 3'd0, addr: 48'h10});
        exp_owner[0] = 1'b0;
        exp_ltag[0]  = 2'd2;
        tick();
        in_req = 2'b00;
        @(negedge clk);
        check("t1_stall_after_capture", 64'(in_stall), 64'h1);
        check("t1_no_req_during_buffer", 64'(mem_req), 64'h0);
        tick();
        @(negedge clk);
        check("t1_issue_req", 64'(mem_req), 64'h1);
        check("t1_stall_cleared", 64'(in_stall), 64'h0);
        check("t1_busy_outstanding", 64'(busy), 64'h1);
        tick();
        tick();
        respond(0, 64'hABCD, 1'b1);
        tick();
        @(negedge clk);
        check("t1_push_single_cycle", 64'(out_push), 64'h0);
        check("t1_data_held", out_data, 64'hABCD);
        check("t1_busy_idle", 64'(busy), 64'h0);
        check_drained("t1");

        // 2/3: both requesters send whenever not stalled, nine requests in total
        do_reset("t2_reset");
        sent = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc >= 2) begin
                check("t2_stall_toggle", 64'(in_stall),
                      ((cyc >= 9) || (cyc % 2 == 1)) ? 64'h1 : 64'h2);
            end
            in_req = 2'b00;
            for (int r = 0; r < 2; r++) begin
                if (!in_stall[r] && sent < 9) begin
                    drive_req(r, 2'(sent), 48'h1000 + 48'(sent));
                    if (sent < 8) begin
                        mem_q.push_back('{tag: 3'(sent), addr: 48'h1000 + 48'(sent)});
                        exp_owner[sent] = 1'(r);
                        exp_ltag[sent]  = 2'(sent);
                    end
                    sent++;
                end
            end
            tick();
        end
        in_req = 2'b00;
        @(negedge clk);
        check("t3_blocked_no_req", 64'(mem_req), 64'h0);
        check("t3_blocked_stall", 64'(in_stall), 64'h1);
        check("t3_busy", 64'(busy), 64'h1);
        check_drained("t3_blocked");
        mem_q.push_back('{tag: 3'd5, addr: 48'h1008});
        respond(5, 64'h5555, 1'b1);
        exp_owner[5] = 1'b0;
        exp_ltag[5]  = 2'd0;
        @(negedge clk);
        check("t3_freed_tag_not_same_cycle", 64'(mem_req), 64'h0);
        tick();
        @(negedge clk);
        check("t3_reissue_tag5", 64'(mem_req), 64'h1);
        check("t3_stall_after_reissue", 64'(in_stall), 64'h0);

        // 4: drain all tags, then hold both requests behind mem_stall
        for (int t = 0; t < 8; t++) begin
            respond(t, 64'hD000 + 64'(t), 1'b1);
        end
        tick();
        @(negedge clk);
        check_drained("t4_pre");
        check("t4_idle_busy", 64'(busy), 64'h0);
        mem_stall = 1'b1;
        drive_req(0, 2'd0, 48'h4000);
        drive_req(1, 2'd1, 48'h4001);
        mem_q.push_back('{tag: 3'd0, addr: 48'h4001});
        mem_q.push_back('{tag: 3'd1, addr: 48'h4000});
        tick();
        in_req = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t4_stalled_no_req", 64'(mem_req), 64'h0);
            check("t4_stalled_full", 64'(in_stall), 64'h3);
            tick();
        end
        mem_stall = 1'b0;
        tick();
        @(negedge clk);
        check("t4_first_after_release", 64'(mem_req), 64'h1);
        check("t4_rr_next_served", 64'(in_stall), 64'h1);
        tick();
        tick();
        @(negedge clk);
        check_drained("t4");

        // 5a: response on an unused tag
        respond(3, 64'h3333, 1'b0);
        @(negedge clk);
        check("t5_bad_tag_no_push", 64'(out_push), 64'h0);
        check("t5_bad_tag_err", 64'(protocol_err), 64'h1);
        tick();
        tick();
        @(negedge clk);
        check("t5_err_sticky", 64'(protocol_err), 64'h1);

        // 5b: request while stalled is dropped
        do_reset("t5_reset");
        mem_stall = 1'b1;
        drive_req(1, 2'd3, 48'hB0B0);
        mem_q.push_back('{tag: 3'd0, addr: 48'hB0B0});
        tick();
        in_req = 2'b00;
        @(negedge clk);
        check("t5_capture_stall", 64'(in_stall), 64'h2);
        check("t5_err_clear_before_drop", 64'(protocol_err), 64'h0);
        drive_req(1, 2'd1, 48'hDEAD);
        tick();
        in_req = 2'b00;
        @(negedge clk);
        check("t5_drop_err", 64'(protocol_err), 64'h1);
        check("t5_drop_stall", 64'(in_stall), 64'h2);
        mem_stall = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_drained("t5b");

        // 6: reset with three tags outstanding, then a late response
        do_reset("t6_reset");
        drive_req(0, 2'd0, 48'h600);
        drive_req(1, 2'd1, 48'h601);
        mem_q.push_back('{tag: 3'd0, addr: 48'h600});
        mem_q.push_back('{tag: 3'd1, addr: 48'h601});
        tick();
        in_req = 2'b00;
        tick();
        drive_req(0, 2'd2, 48'h602);
        mem_q.push_back('{tag: 3'd2, addr: 48'h602});
        tick();
        in_req = 2'b00;
        tick();
        tick();
        @(negedge clk);
        check("t6_busy_before_reset", 64'(busy), 64'h1);
        check_drained("t6_issued");
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_idle("t6_mid_reset");
        rst = 1'b0;
        tick();
        respond(1, 64'h1111, 1'b0);
        @(negedge clk);
        check("t6_late_no_push", 64'(out_push), 64'h0);
        check("t6_late_err", 64'(protocol_err), 64'h1);
        tick();
        @(negedge clk);
        check_drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
